// File: rtl/fifo_wptr_full_ctrl.sv
// Write-side pointer/status controller for the async FIFO: write pointer, gray export,
// read-pointer synchronizer, full/almost_full/level. Optional sticky overflow flag: WFIFO_OVF_FLAG_EN.
module fifo_wptr_full_ctrl #(
    parameter int ADDR_WIDTH   = 4,
    parameter int AFULL_THRESH = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH:0]   rptr_gray_async,
    output logic                  wr_fire,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH:0]   wptr_gray,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   wlevel
`ifdef WFIFO_OVF_FLAG_EN
    ,
    output logic                  overflow
`endif
);

    localparam int PW = ADDR_WIDTH + 1;
    // Full when the write pointer is one lap ahead: top two gray bits inverted, rest equal.
    localparam logic [ADDR_WIDTH:0] FULL_MASK = PW'(3) << (ADDR_WIDTH - 1);
    localparam logic [ADDR_WIDTH:0] AFULL_LVL = AFULL_THRESH[ADDR_WIDTH:0];

    logic [ADDR_WIDTH:0] wbin;
    logic [ADDR_WIDTH:0] rq1;
    logic [ADDR_WIDTH:0] rq2;
    logic [ADDR_WIDTH:0] rbin_s;
    logic [ADDR_WIDTH:0] wbin_next;
    logic [ADDR_WIDTH:0] wgray_next;
    logic [ADDR_WIDTH:0] level_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rq1 <= '0;
            rq2 <= '0;
        end else begin
            rq1 <= rptr_gray_async;
            rq2 <= rq1;
        end
    end

    always_comb begin
        rbin_s = '0;
        for (int i = 0; i <= ADDR_WIDTH; i++) begin
            rbin_s[i] = ^(rq2 >> i);
        end
    end

    assign wr_fire    = wr_en & ~full;
    assign wbin_next  = wbin + PW'(wr_fire);
    assign wgray_next = wbin_next ^ (wbin_next >> 1);
    assign level_next = wbin_next - rbin_s;
    assign waddr      = wbin[ADDR_WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbin        <= '0;
            wptr_gray   <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            wlevel      <= '0;
        end else begin
            wbin        <= wbin_next;
            wptr_gray   <= wgray_next;
            full        <= (wgray_next == (rq2 ^ FULL_MASK));
            almost_full <= (level_next >= AFULL_LVL);
            wlevel      <= level_next;
        end
    end

`ifdef WFIFO_OVF_FLAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (wr_en && full) begin
            overflow <= 1'b1;
        end
    end
`else
    // Writes attempted while full are dropped without record.
`endif

endmodule

// File: tb/tb_fifo_wptr_full_ctrl.sv
// Directed bench for fifo_wptr_full_ctrl: reset, fill, write-while-full, release latency,
// wrap with a tracking reader, async reset mid-fill.
module tb_fifo_wptr_full_ctrl;

    logic       clk;
    logic       clk_en;
    logic       rst_n;
    logic       wr_en;
    logic [4:0] rptr_gray_async;
    logic       wr_fire;
    logic [3:0] waddr;
    logic [4:0] wptr_gray;
    logic       full;
    logic       almost_full;
    logic [4:0] wlevel;
`ifdef WFIFO_OVF_FLAG_EN
    logic       overflow;
`endif

    int n_checks;
    int n_errors;

    fifo_wptr_full_ctrl #(.ADDR_WIDTH(4), .AFULL_THRESH(12)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .wr_en           (wr_en),
        .rptr_gray_async (rptr_gray_async),
        .wr_fire         (wr_fire),
        .waddr           (waddr),
        .wptr_gray       (wptr_gray),
        .full            (full),
        .almost_full     (almost_full),
        .wlevel          (wlevel)
`ifdef WFIFO_OVF_FLAG_EN
        ,
        .overflow        (overflow)
`endif
    );

    initial clk = 1'b0;
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] gray5(input int n);
        logic [4:0] b;
        b = 5'(n);
        return b ^ (b >> 1);
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_waddr"}, 32'(waddr), 32'd0);
        check({tag, "_gray"},  32'(wptr_gray), 32'd0);
        check({tag, "_full"},  32'(full), 32'd0);
        check({tag, "_afull"}, 32'(almost_full), 32'd0);
        check({tag, "_level"}, 32'(wlevel), 32'd0);
        check({tag, "_fire"},  32'(wr_fire), 32'd0);
    endtask

    initial begin
        logic [4:0] prev_gray;
        int         addr_wraps;
        int         gray_wraps;
        logic [3:0] prev_addr;

        n_checks = 0;
        n_errors = 0;
        clk_en = 1'b0;
        rst_n = 1'b1;
        wr_en = 1'b0;
        rptr_gray_async = 5'd0;

        // async reset with the clock stopped
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst");
`ifdef WFIFO_OVF_FLAG_EN
        check("rst_ovf", 32'(overflow), 32'd0);
`endif
        clk_en = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check_all_zero("rel");

        // fill 16
        for (int i = 1; i <= 16; i++) begin
            wr_en = 1'b1;
            #1;
            check("fill_fire", 32'(wr_fire), 32'd1);
            tick();
            check("fill_level", 32'(wlevel), 32'(i));
            check("fill_afull", 32'(almost_full), (i >= 12) ? 32'd1 : 32'd0);
            check("fill_full", 32'(full), (i == 16) ? 32'd1 : 32'd0);
            check("fill_waddr", 32'(waddr), 32'(i % 16));
            check("fill_gray", 32'(wptr_gray), 32'(gray5(i)));
        end
        check("full_gray", 32'(wptr_gray), 32'h18);

        // writes while full
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1;
            #1;
            check("ovf_fire", 32'(wr_fire), 32'd0);
            tick();
            check("ovf_gray", 32'(wptr_gray), 32'h18);
            check("ovf_level", 32'(wlevel), 32'd16);
            check("ovf_full", 32'(full), 32'd1);
`ifdef WFIFO_OVF_FLAG_EN
            check("ovf_flag", 32'(overflow), 32'd1);
`endif
        end

        // release one slot: visible only after the third edge
        wr_en = 1'b0;
        rptr_gray_async = 5'b00001;
        for (int e = 1; e <= 3; e++) begin
            tick();
            check("relse_full", 32'(full), (e == 3) ? 32'd0 : 32'd1);
            check("relse_level", 32'(wlevel), (e == 3) ? 32'd15 : 32'd16);
`ifdef WFIFO_OVF_FLAG_EN
            check("relse_ovf", 32'(overflow), 32'd1);
`endif
        end
        wr_en = 1'b1;
        #1;
        check("refill_fire", 32'(wr_fire), 32'd1);
        tick();
        check("refill_full", 32'(full), 32'd1);
        check("refill_gray", 32'(wptr_gray), 32'h19);
        check("refill_level", 32'(wlevel), 32'd16);
        wr_en = 1'b0;

        // reset, then wrap with a reader tracking the writer
        rptr_gray_async = 5'd0;
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst2");
`ifdef WFIFO_OVF_FLAG_EN
        check("rst2_ovf", 32'(overflow), 32'd0);
`endif
        rst_n = 1'b1;
        tick();
        prev_gray = wptr_gray;
        prev_addr = waddr;
        addr_wraps = 0;
        gray_wraps = 0;
        for (int n = 1; n <= 40; n++) begin
            wr_en = 1'b1;
            rptr_gray_async = gray5(n - 1);
            tick();
            check("wrap_waddr", 32'(waddr), 32'(n % 16));
            check("wrap_gray", 32'(wptr_gray), 32'(gray5(n)));
            check("wrap_hamming", 32'($countones(prev_gray ^ wptr_gray)), 32'd1);
            check("wrap_full", 32'(full), 32'd0);
            check("wrap_level", 32'(wlevel), 32'((n < 3) ? n : 3));
            if (prev_addr == 4'd15 && waddr == 4'd0) addr_wraps++;
            if (prev_gray == 5'b10000 && wptr_gray == 5'b00000) gray_wraps++;
            prev_gray = wptr_gray;
            prev_addr = waddr;
        end
        check("addr_wraps", 32'(addr_wraps), 32'd2);
        check("gray_wraps", 32'(gray_wraps), 32'd1);
        wr_en = 1'b0;

        // async reset mid-fill
        rptr_gray_async = 5'd0;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();
        tick();
        for (int n = 1; n <= 7; n++) begin
            wr_en = 1'b1;
            tick();
            check("mid_level", 32'(wlevel), 32'(n));
        end
        wr_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_rst");
        rst_n = 1'b1;
        wr_en = 1'b1;
        tick();
        check("post_waddr", 32'(waddr), 32'd1);
        check("post_gray", 32'(wptr_gray), 32'd1);
        check("post_level", 32'(wlevel), 32'd1);
        wr_en = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
